// File: rtl/credit_tracker_if.sv
// Credit tracker bus: allocator/downstream strobes in, per-VC credit state out.
interface credit_tracker_if #(
  parameter int NUM_VC = 2,
  parameter int CW     = 3
);
  logic [NUM_VC-1:0]    decr_i;
  logic [NUM_VC-1:0]    incr_i;
  logic [NUM_VC-1:0]    credit_en_o;
  logic [NUM_VC-1:0]    credit_low_o;
  logic [NUM_VC*CW-1:0] credit_cnt_o;
  logic                 all_home_o;
  logic [NUM_VC-1:0]    err_underflow_o;
  logic [NUM_VC-1:0]    err_overflow_o;

  // Allocator / credit-return side.
  modport master (
    output decr_i, incr_i,
    input  credit_en_o, credit_low_o, credit_cnt_o, all_home_o,
           err_underflow_o, err_overflow_o
  );

  // Tracker side.
  modport slave (
    input  decr_i, incr_i,
    output credit_en_o, credit_low_o, credit_cnt_o, all_home_o,
           err_underflow_o, err_overflow_o
  );
endinterface

// File: rtl/credit_tracker.sv
// Per-output-port credit tracker: NUM_VC independent saturating credit
// counters with low-watermark, all-home and sticky error flags.

// One VC lane: saturating counter plus sticky error flags.
module credit_vc #(
  parameter int DEPTH  = 4,
  parameter int LOW_WM = 1,
  parameter int CW     = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          decr,
  input  logic          incr,
  output logic [CW-1:0] cnt,
  output logic          en,
  output logic          low,
  output logic          home,
  output logic          uf,
  output logic          of
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LOW  = CW'(LOW_WM);

  logic is_zero;
  logic is_full;

  assign is_zero = (cnt == '0);
  assign is_full = (cnt == FULL);

  // Counter update: simultaneous incr+decr cancels at any count; single
  // strobes saturate at 0/FULL (checked before the add, so no wrap when FULL
  // is all-ones) and latch the matching sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= FULL;
      uf  <= 1'b0;
      of  <= 1'b0;
    end else begin
      case ({decr, incr})
        2'b10: begin
          if (is_zero) uf  <= 1'b1;
          else         cnt <= cnt - CW'(1);
        end
        2'b01: begin
          if (is_full) of  <= 1'b1;
          else         cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status flags are decoded from registered state only.
  assign en   = ~is_zero;
  assign low  = (cnt <= LOW);
  assign home = is_full;
endmodule

// Top: array of VC lanes wired onto the tracker bus.
module credit_tracker #(
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 4,
  parameter int LOW_WM = 1,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  credit_tracker_if.slave   bus
);
  logic [NUM_VC-1:0][CW-1:0] cnt;
  logic [NUM_VC-1:0]         en;
  logic [NUM_VC-1:0]         low;
  logic [NUM_VC-1:0]         home;
  logic [NUM_VC-1:0]         uf;
  logic [NUM_VC-1:0]         of;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    credit_vc #(
      .DEPTH  (DEPTH),
      .LOW_WM (LOW_WM),
      .CW     (CW)
    ) u_vc (
      .clk  (clk),
      .rst  (rst),
      .decr (bus.decr_i[v]),
      .incr (bus.incr_i[v]),
      .cnt  (cnt[v]),
      .en   (en[v]),
      .low  (low[v]),
      .home (home[v]),
      .uf   (uf[v]),
      .of   (of[v])
    );
  end

  // Packed array layout puts VC v at bits [v*CW +: CW].
  assign bus.credit_cnt_o    = cnt;
  assign bus.credit_en_o     = en;
  assign bus.credit_low_o    = low;
  assign bus.all_home_o      = &home;
  assign bus.err_underflow_o = uf;
  assign bus.err_overflow_o  = of;
endmodule

// File: tb/tb_credit_tracker.sv
// Directed bench for credit_tracker: main 2-VC/DEPTH=4 instance plus a
// 1-VC/DEPTH=3 instance to exercise saturation at an all-ones count.
module tb_credit_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  credit_tracker_if #(.NUM_VC(2), .CW(3)) bus ();
  credit_tracker_if #(.NUM_VC(1), .CW(2)) b3 ();

  credit_tracker #(.NUM_VC(2), .DEPTH(4), .LOW_WM(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  credit_tracker #(.NUM_VC(1), .DEPTH(3), .LOW_WM(1)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected packed count {VC1, VC0}, 3 bits each.
  function automatic int pk(input int c1, input int c0);
    return (c1 << 3) | c0;
  endfunction

  // Inputs change on the falling edge; outputs are read on the next falling
  // edge, one rising edge later.
  task automatic cyc(input logic [1:0] d, input logic [1:0] i);
    bus.decr_i = d;
    bus.incr_i = i;
    @(negedge clk);
  endtask

  initial begin
    bus.decr_i = '0; bus.incr_i = '0;
    b3.decr_i  = '0; b3.incr_i  = '0;

    // Reset held two cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cnt",  32'(bus.credit_cnt_o),    pk(4, 4));
    chk("rst_en",   32'(bus.credit_en_o),     'b11);
    chk("rst_low",  32'(bus.credit_low_o),    'b00);
    chk("rst_home", 32'(bus.all_home_o),      1);
    chk("rst_uf",   32'(bus.err_underflow_o), 0);
    chk("rst_of",   32'(bus.err_overflow_o),  0);
    chk("rst_cnt3", 32'(b3.credit_cnt_o),     3);

    // Drain VC0.
    cyc(2'b01, 2'b00);
    chk("dr1_cnt",  32'(bus.credit_cnt_o), pk(4, 3));
    chk("dr1_home", 32'(bus.all_home_o),   0);
    chk("dr1_low",  32'(bus.credit_low_o), 'b00);
    cyc(2'b01, 2'b00);
    chk("dr2_cnt",  32'(bus.credit_cnt_o), pk(4, 2));
    chk("dr2_low",  32'(bus.credit_low_o), 'b00);
    cyc(2'b01, 2'b00);
    chk("dr3_cnt",  32'(bus.credit_cnt_o), pk(4, 1));
    chk("dr3_low",  32'(bus.credit_low_o), 'b01);
    chk("dr3_en",   32'(bus.credit_en_o),  'b11);
    cyc(2'b01, 2'b00);
    chk("dr4_cnt",  32'(bus.credit_cnt_o), pk(4, 0));
    chk("dr4_en",   32'(bus.credit_en_o),  'b10);
    chk("dr4_low",  32'(bus.credit_low_o), 'b01);

    // Simultaneous strobes at 0 and at DEPTH.
    cyc(2'b01, 2'b01);
    chk("sim0_cnt", 32'(bus.credit_cnt_o),    pk(4, 0));
    chk("sim0_uf",  32'(bus.err_underflow_o), 0);
    cyc(2'b10, 2'b10);
    chk("simF_cnt", 32'(bus.credit_cnt_o),    pk(4, 0));
    chk("simF_of",  32'(bus.err_overflow_o),  0);

    // Refill VC0.
    cyc(2'b00, 2'b01);
    chk("rf1_cnt",  32'(bus.credit_cnt_o), pk(4, 1));
    chk("rf1_en",   32'(bus.credit_en_o),  'b11);
    chk("rf1_low",  32'(bus.credit_low_o), 'b01);
    cyc(2'b00, 2'b01);
    chk("rf2_cnt",  32'(bus.credit_cnt_o), pk(4, 2));
    chk("rf2_low",  32'(bus.credit_low_o), 'b00);
    cyc(2'b00, 2'b01);
    chk("rf3_home", 32'(bus.all_home_o),   0);
    cyc(2'b00, 2'b01);
    chk("rf4_cnt",  32'(bus.credit_cnt_o), pk(4, 4));
    chk("rf4_home", 32'(bus.all_home_o),   1);

    // Overflow on VC0, sticky.
    cyc(2'b00, 2'b01);
    chk("of_cnt",   32'(bus.credit_cnt_o),   pk(4, 4));
    chk("of_flag",  32'(bus.err_overflow_o), 'b01);
    cyc(2'b00, 2'b00);
    chk("of_hold",  32'(bus.err_overflow_o), 'b01);
    chk("of_uf",    32'(bus.err_underflow_o), 0);

    // Drain VC1 then underflow, sticky across a later return.
    repeat (4) cyc(2'b10, 2'b00);
    chk("dv1_cnt",  32'(bus.credit_cnt_o),    pk(0, 4));
    chk("dv1_en",   32'(bus.credit_en_o),     'b01);
    chk("dv1_home", 32'(bus.all_home_o),      0);
    cyc(2'b10, 2'b00);
    chk("uf_cnt",   32'(bus.credit_cnt_o),    pk(0, 4));
    chk("uf_flag",  32'(bus.err_underflow_o), 'b10);
    cyc(2'b00, 2'b00);
    chk("uf_hold",  32'(bus.err_underflow_o), 'b10);
    cyc(2'b00, 2'b10);
    chk("uf_inc",   32'(bus.credit_cnt_o),    pk(1, 4));
    chk("uf_keep",  32'(bus.err_underflow_o), 'b10);
    chk("uf_of",    32'(bus.err_overflow_o),  'b01);

    // Move to {2,0}, then reset with strobes present.
    cyc(2'b01, 2'b10);
    chk("mv_cnt",   32'(bus.credit_cnt_o), pk(2, 3));
    repeat (3) cyc(2'b01, 2'b00);
    chk("pre_cnt",  32'(bus.credit_cnt_o), pk(2, 0));
    rst = 1'b1;
    cyc(2'b11, 2'b00);
    rst = 1'b0;
    bus.decr_i = '0;
    chk("mr_cnt",   32'(bus.credit_cnt_o),    pk(4, 4));
    chk("mr_uf",    32'(bus.err_underflow_o), 0);
    chk("mr_of",    32'(bus.err_overflow_o),  0);
    chk("mr_home",  32'(bus.all_home_o),      1);
    chk("mr_en",    32'(bus.credit_en_o),     'b11);

    // DEPTH=3: full count is all-ones and must saturate, not wrap.
    b3.incr_i = 1'b1;
    @(negedge clk);
    b3.incr_i = 1'b0;
    chk("d3_of_cnt",  32'(b3.credit_cnt_o),   3);
    chk("d3_of_flag", 32'(b3.err_overflow_o), 1);
    chk("d3_home",    32'(b3.all_home_o),     1);
    b3.decr_i = 1'b1;
    repeat (3) @(negedge clk);
    b3.decr_i = 1'b0;
    chk("d3_dr_cnt",  32'(b3.credit_cnt_o),   0);
    chk("d3_dr_en",   32'(b3.credit_en_o),    0);
    chk("d3_dr_uf",   32'(b3.err_underflow_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/credit_tracker.md
# credit_tracker

Per-output-port credit tracker for the NoC router. It generalises the single-channel credit counter to NUM_VC independent virtual-channel counters, each sized to a parameterised downstream buffer depth. It supports simultaneous credit return and consume, low-watermark flags, an all-credits-home indication and sticky protocol-error flags. It sits between the switch allocator, which consumes credits, and the downstream router's credit-return wires.

## Interface

Parameters:
- NUM_VC, 2: number of virtual channels tracked; each has its own counter.
- DEPTH, 4: downstream buffer slots per VC; also the reset and maximum credit count. Must be ≥ 1.
- LOW_WM, 1: low-watermark threshold; must be < DEPTH.
- CW, $clog2(DEPTH+1): counter width; derived, not to be overridden.

Ports:
- clk  in  1  router clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- decr_i  in  NUM_VC  per-VC flit-sent strobe; consumes one credit.
- incr_i  in  NUM_VC  per-VC credit-return strobe from downstream; restores one credit.
- credit_en_o  out  NUM_VC  per-VC, 1 when the VC count is non-zero.
- credit_low_o  out  NUM_VC  per-VC, 1 when the VC count ≤ LOW_WM.
- credit_cnt_o  out  NUM_VC*CW  packed counts; VC v occupies bits [v*CW +: CW].
- all_home_o  out  1  1 when every VC count equals DEPTH (downstream empty).
- err_underflow_o  out  NUM_VC  sticky per-VC flag: decr_i was seen while the count was 0.
- err_overflow_o  out  NUM_VC  sticky per-VC flag: incr_i was seen while the count was DEPTH.

## Operation

- Each VC has one register, cnt[v], of CW bits. All outputs are combinational functions of registered state only; there is no input-to-output combinational path.
- Per-cycle update for each VC, evaluated independently:
  - decr=1, incr=1: cnt unchanged. This is legal at any count, including 0 and DEPTH. No error flag is set.
  - decr=1, incr=0, cnt>0: cnt-1.
  - decr=1, incr=0, cnt==0: cnt held at 0. err_underflow_o[v] is set.
  - decr=0, incr=1, cnt<DEPTH: cnt+1.
  - decr=0, incr=1, cnt==DEPTH: cnt held at DEPTH. err_overflow_o[v] is set.
  - neither: hold.
- Counts saturate and never wrap. Arithmetic is done in CW bits, so with DEPTH=2^k-1 the maximum value is all-ones and must not wrap to 0.
- Error flags are sticky; only rst clears them. A flag never changes the counter beyond the saturating hold described above.
- Derived outputs:
  - credit_en_o[v] = (cnt[v] != 0).
  - credit_low_o[v] = (cnt[v] <= LOW_WM).
  - all_home_o = AND over all v of (cnt[v] == DEPTH).
- VCs are fully independent. Activity on one VC never affects another VC's count or flags.

## Timing

- Reset (rst=1 sampled at a clk edge):
  - every cnt = DEPTH
  - credit_en_o = all 1
  - credit_low_o = all 0
  - all_home_o = 1
  - credit_cnt_o = DEPTH in every field
  - both error vectors = 0
- rst has priority over incr_i/decr_i in the same cycle. Strobes present during reset are discarded.
- Reset mid-operation restores the full reset state on the next edge, regardless of counts or flags.
- Latency:
  - A strobe sampled at edge n is reflected on credit_cnt_o and all derived outputs after edge n, i.e. visible in cycle n+1.
  - An error flag asserts in the cycle after the offending strobe.
- The allocator must use credit_en_o as seen in the current cycle. Back-to-back decr on every cycle is legal and drains DEPTH credits in DEPTH cycles.
- Credits returned in cycle n cannot be consumed until cycle n+1 (no bypass). The one exception is a simultaneous incr+decr at count 0, which is absorbed with no underflow.

## Test plan

Parameters for all scenarios: NUM_VC=2, DEPTH=4, LOW_WM=1, CW=3.

- **Reset:** assert rst 2 cycles, then release → cnt={4,4}, credit_en_o=2'b11, credit_low_o=2'b00, all_home_o=1, errors 0.
- **Drain and refill VC0:**
  - decr_i[0]=1 for 4 cycles → VC0 count 3,2,1,0. credit_low_o[0] rises when the count reaches 1. credit_en_o[0]=0 after the 4th edge. all_home_o=0 after the first edge. VC1 stays at 4.
  - Then incr_i[0] for 4 cycles → VC0 count back to 4, all_home_o=1.
- **Simultaneous events:**
  - With VC0 at 0, drive incr_i[0]=decr_i[0]=1 → VC0 stays 0, no underflow.
  - With VC1 at 4, drive both strobes → VC1 stays 4, no overflow.
- **Underflow:** VC1 at 0, decr_i[1]=1 for 1 cycle → VC1 count stays 0, err_underflow_o=2'b10 and held. A later incr_i[1] gives count 1 with the flag still 1.
- **Overflow:** VC0 at 4, incr_i[0]=1 → VC0 count stays 4, err_overflow_o=2'b01 and held. VC1 is unaffected.
- **Reset mid-operation:** counts {2,0} with err_underflow_o[1]=1; assert rst together with decr_i=2'b11 → next cycle counts {4,4}, all flags 0, all_home_o=1.
